// File: rtl/xkold_pkg.sv
// -----------------------------------------------------------------------------
// xkold_pkg
// Shared definitions for the x_k-1 stream reader: FSM state encoding and the
// default vector geometry of one solver cluster.
// -----------------------------------------------------------------------------
package xkold_pkg;

    // Default geometry: 9 equations per cluster, 32-bit elements, 4-bit index.
    localparam int XK_N  = 9;
    localparam int XK_W  = 32;
    localparam int XK_IW = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/delta_abs_sat.sv
// -----------------------------------------------------------------------------
// delta_abs_sat
// Wrapping difference a-b and its absolute value. The one value whose magnitude
// does not fit in W-1 bits (the most-negative difference) saturates to the
// largest positive value.
//
// Ports:
//   i_a    in  W  minuend   (current iterate element)
//   i_b    in  W  subtrahend (previous iterate element)
//   o_diff out W  a-b, two's complement, wraps modulo 2^W
//   o_abs  out W  |a-b|, saturated to 2^(W-1)-1
// -----------------------------------------------------------------------------
module delta_abs_sat #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic [W-1:0] o_abs
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0] w_diff;

    assign w_diff = i_a - i_b;
    assign o_diff = w_diff;

    always_comb begin
        o_abs = w_diff;
        if (w_diff == MOST_NEG) begin
            o_abs = MOST_POS;
        end else if (w_diff[W-1]) begin
            o_abs = (~w_diff) + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/xkold_stream_reader.sv
// -----------------------------------------------------------------------------
// xkold_stream_reader
// Read side of the previous-iterate (x_k-1) vector register. A start pulse in
// IDLE snapshots the whole vector into a shadow register; the shadow is then
// streamed one element per valid/ready handshake in equation order. A one-cycle
// done pulse follows the last handshake.
//
// Optional feature (macro XKOLD_DELTA_EN): the current iterate xk_in is
// snapshotted alongside, each beat also carries xk - xk_old, and the largest
// |delta| over handshaken elements is tracked in max_abs_delta.
//
// Ports:
//   clk           in  1    rising-edge clock
//   rst           in  1    synchronous active-high reset
//   start         in  1    snapshot + stream request (ignored while streaming)
//   vector_in     in  W*N  x_k-1 vector, element i at [W*i +: W]
//   xk_in         in  W*N  current iterate        (XKOLD_DELTA_EN only)
//   out_delta     out W    xk[i] - xk_old[i]      (XKOLD_DELTA_EN only)
//   max_abs_delta out W    running max |delta|    (XKOLD_DELTA_EN only)
//   busy          out 1    streaming in progress
//   out_data      out W    current element
//   out_index     out IW   index of out_data
//   out_valid     out 1    element valid
//   out_ready     in  1    consumer accepts element
//   out_last      out 1    element N-1 on the bus
//   done          out 1    one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module xkold_stream_reader
    import xkold_pkg::*;
#(
    parameter int N  = XK_N,
    parameter int W  = XK_W,
    parameter int IW = XK_IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W*N-1:0]  vector_in,
`ifdef XKOLD_DELTA_EN
    input  logic [W*N-1:0]  xk_in,
    output logic [W-1:0]    out_delta,
    output logic [W-1:0]    max_abs_delta,
`endif
    output logic            busy,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_index,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [IW-1:0]  r_index;
    logic           r_done;
    logic [W-1:0]   r_shadow [N];
    logic [W-1:0]   w_vec    [N];

    logic           w_accept;
    logic           w_handshake;
    logic           w_at_last;

    // Unpack the flat bus into per-element lanes.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_vec[gi] = vector_in[W*gi +: W];
    end

    assign w_accept    = (r_state == IDLE) && start;
    assign w_at_last   = (r_index == LAST_IDX);
    // out_valid is a pure function of state, so out_ready never reaches
    // out_valid/out_data combinationally; it only steers the next state.
    assign w_handshake = out_valid && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = STREAM;
            STREAM:  if (w_handshake && w_at_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid = (r_state == STREAM);
        busy      = (r_state == STREAM);
        out_last  = (r_state == STREAM) && w_at_last;
    end

    // ---------------- index, done pulse, snapshot ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_done <= w_handshake && w_at_last;
            if (w_accept) begin
                r_index <= '0;
                for (int i = 0; i < N; i++) begin
                    r_shadow[i] <= w_vec[i];
                end
            end else if (w_handshake) begin
                // Wrap back to 0 after the last element so the idle bus
                // presents element 0 rather than an out-of-range index.
                r_index <= w_at_last ? '0 : r_index + 1'b1;
            end
        end
    end

    assign out_data  = r_shadow[r_index];
    assign out_index = r_index;
    assign done      = r_done;

`ifdef XKOLD_DELTA_EN
    logic [W-1:0] r_xk_shadow [N];
    logic [W-1:0] w_xk_vec    [N];
    logic [W-1:0] w_abs;
    logic [W-1:0] r_max_abs;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack_xk
        assign w_xk_vec[gi] = xk_in[W*gi +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_xk_shadow[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N; i++) begin
                r_xk_shadow[i] <= w_xk_vec[i];
            end
        end
    end

    delta_abs_sat #(
        .W (W)
    ) u_delta_abs_sat (
        .i_a    (r_xk_shadow[r_index]),
        .i_b    (r_shadow[r_index]),
        .o_diff (out_delta),
        .o_abs  (w_abs)
    );

    // Only handshaken beats contribute, so a stalled element is counted once
    // and the value freezes after the last beat until the next start.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_max_abs <= '0;
        end else if (w_handshake && (w_abs > r_max_abs)) begin
            r_max_abs <= w_abs;
        end
    end

    assign max_abs_delta = r_max_abs;
`endif

endmodule

// File: tb/tb_xkold_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_xkold_stream_reader
// Directed bench for xkold_stream_reader (default geometry N=9, W=32, IW=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Define XKOLD_DELTA_EN to also exercise the delta/max-abs-delta outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xkold_stream_reader;

    localparam int N  = 9;
    localparam int W  = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W*N-1:0]  vector_in;
    logic            busy;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_index;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            done;
`ifdef XKOLD_DELTA_EN
    logic [W*N-1:0]  xk_in;
    logic [W-1:0]    out_delta;
    logic [W-1:0]    max_abs_delta;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xkold_stream_reader #(
        .N  (N),
        .W  (W),
        .IW (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vector_in     (vector_in),
`ifdef XKOLD_DELTA_EN
        .xk_in         (xk_in),
        .out_delta     (out_delta),
        .max_abs_delta (max_abs_delta),
`endif
        .busy          (busy),
        .out_data      (out_data),
        .out_index     (out_index),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .done          (done)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load_vec(input logic [31:0] base);
        for (int i = 0; i < N; i++) vector_in[W*i +: W] = base + 32'(i);
    endtask

    // --------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        load_vec(32'h55);
        step(); step();
        checks++;
        if ({busy, out_valid, out_last, done, out_data, out_index} !== {4'b0000, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b last=%b done=%b data=%h idx=%0d, want all zero",
                     busy, out_valid, out_last, done, out_data, out_index);
        end
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b done=%b, want 000", busy, out_valid, done);
        end
        $display("reset: outputs cleared and idle");
    endtask

    // --------------------------------------------------------------------
    task automatic test_stream_basic();
        load_vec(32'h10);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({out_valid, busy, out_data, out_index, out_last, done} !==
                {1'b1, 1'b1, 32'h10 + 32'(i), 4'(i), (i == N-1), 1'b0}) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b busy=%b data=%h idx=%0d last=%b done=%b, want data=%h idx=%0d last=%b",
                         i, out_valid, busy, out_data, out_index, out_last, done, 32'h10 + 32'(i), i, (i == N-1));
            end
            $display("basic: beat idx=%0d data=%h last=%b", out_index, out_data, out_last);
            step();
        end
        checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL basic_done: got valid=%b busy=%b done=%b, want 0 0 1", out_valid, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got done=%b, want 0", done);
        end
    endtask

    // --------------------------------------------------------------------
    task automatic test_stall();
        int k = 0;
        int cyc = 0;
        load_vec(32'h10);
        out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        while (k < N && cyc < 60) begin
            out_ready = (cyc % 2 == 0);
            checks++;
            if ({out_valid, out_data, out_index, out_last, done} !==
                {1'b1, 32'h10 + 32'(k), 4'(k), (k == N-1), 1'b0}) begin
                errors++;
                $display("FAIL stall_cyc%0d: got v=%b data=%h idx=%0d last=%b done=%b, want data=%h idx=%0d last=%b",
                         cyc, out_valid, out_data, out_index, out_last, done, 32'h10 + 32'(k), k, (k == N-1));
            end
            $display("stall: cyc=%0d ready=%b idx=%0d data=%h", cyc, out_ready, out_index, out_data);
            step();
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (k !== N) begin
            errors++;
            $display("FAIL stall_budget: got %0d handshakes, want %0d", k, N);
        end
        checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL stall_done: got valid=%b busy=%b done=%b, want 0 0 1", out_valid, busy, done);
        end
        step();
    endtask

    // --------------------------------------------------------------------
    task automatic test_snapshot();
        load_vec(32'hA0);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        vector_in = '1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({out_valid, out_data, out_index} !== {1'b1, 32'hA0 + 32'(i), 4'(i)}) begin
                errors++;
                $display("FAIL snapshot_beat%0d: got v=%b data=%h idx=%0d, want data=%h", i,
                         out_valid, out_data, out_index, 32'hA0 + 32'(i));
            end
            $display("snapshot: beat idx=%0d data=%h", out_index, out_data);
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL snapshot_done: got done=%b, want 1", done);
        end
        step();
    endtask

    // --------------------------------------------------------------------
    task automatic test_back_to_back();
        load_vec(32'h20);
        out_ready = 1'b1; start = 1'b1;
        step();
        for (int i = 0; i < N; i++) begin
            // Toggle start and disturb the source: neither may restart the stream.
            start = i[0];
            vector_in[W*0 +: W] = 32'hDEAD0000 + 32'(i);
            checks++;
            if ({out_valid, out_data, out_index} !== {1'b1, 32'h20 + 32'(i), 4'(i)}) begin
                errors++;
                $display("FAIL b2b_first_beat%0d: got v=%b data=%h idx=%0d, want data=%h idx=%0d", i,
                         out_valid, out_data, out_index, 32'h20 + 32'(i), i);
            end
            $display("b2b: stream1 idx=%0d data=%h start=%b", out_index, out_data, start);
            step();
        end
        // Done cycle: state is IDLE, so this start is accepted.
        load_vec(32'h30);
        start = 1'b1;
        checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_done: got valid=%b busy=%b done=%b, want 0 0 1", out_valid, busy, done);
        end
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({out_valid, out_data, out_index, done} !== {1'b1, 32'h30 + 32'(i), 4'(i), 1'b0}) begin
                errors++;
                $display("FAIL b2b_second_beat%0d: got v=%b data=%h idx=%0d done=%b, want data=%h", i,
                         out_valid, out_data, out_index, done, 32'h30 + 32'(i));
            end
            $display("b2b: stream2 idx=%0d data=%h", out_index, out_data);
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: got done=%b, want 1", done);
        end
        step();
    endtask

    // --------------------------------------------------------------------
    task automatic test_rst_mid_stream();
        load_vec(32'h40);
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({out_valid, out_index, out_data} !== {1'b1, 4'd4, 32'h44}) begin
            errors++;
            $display("FAIL rst_pre: got v=%b idx=%0d data=%h, want 1 4 00000044", out_valid, out_index, out_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, out_valid, out_last, done, out_data, out_index} !== {4'b0000, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL rst_abort: got busy=%b valid=%b last=%b done=%b data=%h idx=%0d, want all zero",
                     busy, out_valid, out_last, done, out_data, out_index);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, done} !== 2'b00) begin
                errors++;
                $display("FAIL rst_quiet%0d: got valid=%b done=%b, want 0 0", i, out_valid, done);
            end
        end
        $display("rst: abort at index 4, bus idle");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({out_valid, out_data, out_index} !== {1'b1, 32'h40 + 32'(i), 4'(i)}) begin
                errors++;
                $display("FAIL rst_restart_beat%0d: got v=%b data=%h idx=%0d, want data=%h", i,
                         out_valid, out_data, out_index, 32'h40 + 32'(i));
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart_done: got done=%b, want 1", done);
        end
        $display("rst: clean restart streamed %0d elements", N);
        step();
    endtask

`ifdef XKOLD_DELTA_EN
    // --------------------------------------------------------------------
    task automatic test_delta();
        logic [31:0] exp_d;
        logic [31:0] exp_max;
        for (int i = 0; i < N; i++) begin
            xk_in[W*i +: W]     = (i == 3) ? 32'h80000000 : 32'd5;
            vector_in[W*i +: W] = (i == 3) ? 32'h0        : 32'd8;
        end
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (max_abs_delta !== 32'h0) begin
            errors++;
            $display("FAIL delta_max_clear: got %h, want 00000000", max_abs_delta);
        end
        exp_max = 32'h0;
        for (int i = 0; i < N; i++) begin
            exp_d = (i == 3) ? 32'h80000000 : 32'hFFFFFFFD;
            checks++;
            if ({out_delta, max_abs_delta} !== {exp_d, exp_max}) begin
                errors++;
                $display("FAIL delta_beat%0d: got delta=%h max=%h, want delta=%h max=%h", i,
                         out_delta, max_abs_delta, exp_d, exp_max);
            end
            $display("delta: idx=%0d delta=%h max=%h", out_index, out_delta, max_abs_delta);
            exp_max = (i >= 3) ? 32'h7FFFFFFF : 32'd3;
            step();
        end
        checks++;
        if ({done, max_abs_delta} !== {1'b1, 32'h7FFFFFFF}) begin
            errors++;
            $display("FAIL delta_done: got done=%b max=%h, want 1 7fffffff", done, max_abs_delta);
        end
        step();
        checks++;
        if (max_abs_delta !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL delta_hold: got %h, want 7fffffff", max_abs_delta);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; vector_in = '0;
`ifdef XKOLD_DELTA_EN
        xk_in = '0;
`endif
        step();
        test_reset();
        test_stream_basic();
        test_stall();
        test_snapshot();
        test_back_to_back();
        test_rst_mid_stream();
`ifdef XKOLD_DELTA_EN
        test_delta();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
